// File: rtl/sja_tx_frame_if.sv
// ============================================================================
// sja_tx_frame_if : request/response bundle between the frame sequencer and
// the SJA1000 single-access bus-cycle engine.  Revision: 1.0
// ============================================================================
`default_nettype none

interface sja_tx_frame_if;
    logic [1:0] bus_wr_rd_en;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_finish;

    modport master (
        output bus_wr_rd_en,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_finish
    );

    modport slave (
        input  bus_wr_rd_en,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_finish
    );
endinterface

`default_nettype wire

// File: rtl/sja_tx_frame.sv
// ============================================================================
// sja_tx_frame : PeliCAN standard-frame transmit sequencer (poll TBS, load TX
// buffer, issue TR) on top of the SJA1000 bus engine.  Revision: 1.0
// ============================================================================
`default_nettype none

module sja_tx_frame #(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_start,
    input  logic [10:0]           tx_id,
    input  logic                  tx_rtr,
    input  logic [3:0]            tx_dlc,
    input  logic [63:0]           tx_data,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_timeout,
    sja_tx_frame_if.master        bus
);

    localparam logic [7:0] c_addr_cmd    = 8'h01;
    localparam logic [7:0] c_addr_status = 8'h02;
    localparam logic [7:0] c_addr_txbuf  = 8'h10;
    localparam logic [7:0] c_cmd_tr      = 8'h01;
    localparam logic [7:0] c_poll_max    = 8'(POLL_MAX);
    localparam logic [1:0] c_acc_none    = 2'b00;
    localparam logic [1:0] c_acc_read    = 2'b01;
    localparam logic [1:0] c_acc_write   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_POLL_RQ = 4'd1,
        S_POLL_WT = 4'd2,
        S_LOAD_RQ = 4'd3,
        S_LOAD_WT = 4'd4,
        S_CMD_RQ  = 4'd5,
        S_CMD_WT  = 4'd6,
        S_DONE    = 4'd7,
        S_FAIL    = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [10:0] id_q, id_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  nbytes_q, nbytes_d;
    logic [1:0]  wr_rd_en_q, wr_rd_en_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    // Only TBS (bit 2) of the status register matters here.
    logic unused_rdata;
    assign unused_rdata = ^{bus.bus_rdata[7:3], bus.bus_rdata[1:0]};

    // TX buffer byte for a given load index: frame info, two ID bytes, payload.
    function automatic logic [7:0] load_byte(
        input logic [3:0]  idx,
        input logic [10:0] id,
        input logic        rtr,
        input logic [3:0]  dlc,
        input logic [63:0] data
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = {1'b0, rtr, 2'b00, dlc};
            4'd1:    b = id[10:3];
            4'd2:    b = {id[2:0], rtr, 4'b0000};
            default: begin
                for (int i = 0; i < 8; i++) begin
                    if (idx == 4'(i + 3)) begin
                        b = data[8*(7-i) +: 8];
                    end
                end
            end
        endcase
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        poll_cnt_d = poll_cnt_q;
        id_d       = id_q;
        rtr_d      = rtr_q;
        dlc_d      = dlc_q;
        data_d     = data_q;
        nbytes_d   = nbytes_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_rd_en_d = c_acc_none;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    id_d       = tx_id;
                    rtr_d      = tx_rtr;
                    dlc_d      = tx_dlc;
                    data_d     = tx_data;
                    nbytes_d   = tx_rtr ? 4'd0 : ((tx_dlc > 4'd8) ? 4'd8 : tx_dlc);
                    idx_d      = 4'd0;
                    poll_cnt_d = 8'd0;
                    state_d    = S_POLL_RQ;
                end
            end
            S_POLL_RQ: state_d = S_POLL_WT;
            S_POLL_WT: begin
                if (bus.bus_finish) begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                    if (bus.bus_rdata[2]) begin
                        state_d = S_LOAD_RQ;
                    end else if (poll_cnt_d == c_poll_max) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_POLL_RQ;
                    end
                end
            end
            S_LOAD_RQ: state_d = S_LOAD_WT;
            S_LOAD_WT: begin
                if (bus.bus_finish) begin
                    if (idx_q == 4'd2 + nbytes_q) begin
                        state_d = S_CMD_RQ;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LOAD_RQ;
                    end
                end
            end
            S_CMD_RQ:  state_d = S_CMD_WT;
            S_CMD_WT:  if (bus.bus_finish) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_FAIL:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so that they are registered
        // and valid during the request cycle itself; addr/wdata then hold.
        case (state_d)
            S_POLL_RQ: begin
                wr_rd_en_d = c_acc_read;
                addr_d     = c_addr_status;
            end
            S_LOAD_RQ: begin
                wr_rd_en_d = c_acc_write;
                addr_d     = c_addr_txbuf + {4'b0000, idx_d};
                wdata_d    = load_byte(idx_d, id_q, rtr_q, dlc_q, data_q);
            end
            S_CMD_RQ: begin
                wr_rd_en_d = c_acc_write;
                addr_d     = c_addr_cmd;
                wdata_d    = c_cmd_tr;
            end
            default: ;
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        timeout_d = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            poll_cnt_q <= 8'd0;
            id_q       <= 11'd0;
            rtr_q      <= 1'b0;
            dlc_q      <= 4'd0;
            data_q     <= 64'd0;
            nbytes_q   <= 4'd0;
            wr_rd_en_q <= c_acc_none;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            id_q       <= id_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            data_q     <= data_d;
            nbytes_q   <= nbytes_d;
            wr_rd_en_q <= wr_rd_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.bus_wr_rd_en = wr_rd_en_q;
    assign bus.bus_addr     = addr_q;
    assign bus.bus_wdata    = wdata_q;
    assign tx_busy          = busy_q;
    assign tx_done          = done_q;
    assign tx_timeout       = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sja_tx_frame.sv
// ============================================================================
// tb_sja_tx_frame : directed vector bench for sja_tx_frame with a small
// bus-engine responder that logs every completed access.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sja_tx_frame;

    localparam int unsigned POLL_MAX = 4;
    localparam int          ENG_LAT  = 3;

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        int          locked;
        int          exp_reads;
        int          exp_nb;
        logic [7:0]  exp_info;
        logic [7:0]  exp_id1;
        logic [7:0]  exp_id2;
        bit          exp_done;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [10:0] tx_id = 11'd0;
    logic        tx_rtr = 1'b0;
    logic [3:0]  tx_dlc = 4'd0;
    logic [63:0] tx_data = 64'd0;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_timeout;

    int checks = 0;
    int errors = 0;

    sja_tx_frame_if bus_if ();

    sja_tx_frame #(.POLL_MAX(POLL_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start),
        .tx_id      (tx_id),
        .tx_rtr     (tx_rtr),
        .tx_dlc     (tx_dlc),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_timeout (tx_timeout),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    // Bus engine: latches the request type, completes ENG_LAT cycles later and
    // logs addr/wdata at completion time, so they must still be held then.
    int   eng_cnt = 0;
    logic eng_wr = 1'b0;
    int   rd_total = 0;
    int   rd_base = 0;
    int   locked_reads = 0;
    acc_t log_q[$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt           <= 0;
            bus_if.bus_finish <= 1'b0;
            bus_if.bus_rdata  <= 8'h00;
        end else begin
            bus_if.bus_finish <= 1'b0;
            if (eng_cnt > 1) begin
                eng_cnt <= eng_cnt - 1;
            end else if (eng_cnt == 1) begin
                eng_cnt           <= 0;
                bus_if.bus_finish <= 1'b1;
                if (!eng_wr) begin
                    rd_total         <= rd_total + 1;
                    bus_if.bus_rdata <= (rd_total + 1 - rd_base > locked_reads) ? 8'h04 : 8'hFB;
                end else begin
                    bus_if.bus_rdata <= 8'h00;
                end
                log_q.push_back('{eng_wr, bus_if.bus_addr, bus_if.bus_wdata});
            end else if (bus_if.bus_wr_rd_en != 2'b00) begin
                eng_wr  <= bus_if.bus_wr_rd_en[1];
                eng_cnt <= ENG_LAT;
            end
        end
    end

    // Pulse counters and protocol watch (back-to-back requests, done/timeout
    // without busy, done together with timeout).
    int   done_cnt = 0;
    int   to_cnt = 0;
    int   proto_err = 0;
    logic prev_rq = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rq <= 1'b0;
        end else begin
            prev_rq <= (bus_if.bus_wr_rd_en != 2'b00);
            if (tx_done)    done_cnt <= done_cnt + 1;
            if (tx_timeout) to_cnt   <= to_cnt + 1;
            if ((prev_rq && bus_if.bus_wr_rd_en != 2'b00) ||
                (tx_done && !tx_busy) || (tx_timeout && !tx_busy) ||
                (tx_done && tx_timeout)) begin
                proto_err <= proto_err + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int num);
        int   lb, db, tb, pb, n, nreads, bad_rd, k;
        bit   fin;
        acc_t ew[$];
        lb = log_q.size();
        db = done_cnt;
        tb = to_cnt;
        pb = proto_err;
        locked_reads = v.locked;
        rd_base      = rd_total;

        @(negedge clk);
        tx_start = 1'b1;
        tx_id    = v.id;
        tx_rtr   = v.rtr;
        tx_dlc   = v.dlc;
        tx_data  = v.data;
        @(negedge clk);
        tx_start = 1'b0;
        tx_id    = ~v.id;
        tx_rtr   = ~v.rtr;
        tx_dlc   = ~v.dlc;
        tx_data  = ~v.data;
        chk($sformatf("v%0d_busy_after_start", num), 64'(tx_busy), 64'd1);
        repeat (3) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;

        fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            if (done_cnt != db || to_cnt != tb) fin = 1'b1;
        end
        chk($sformatf("v%0d_finished", num), 64'(fin), 64'd1);
        repeat (30) @(negedge clk);

        chk($sformatf("v%0d_busy_idle", num), 64'(tx_busy), 64'd0);
        chk($sformatf("v%0d_done_pulses", num), 64'(done_cnt - db), 64'(v.exp_done ? 1 : 0));
        chk($sformatf("v%0d_timeout_pulses", num), 64'(to_cnt - tb), 64'(v.exp_done ? 0 : 1));
        chk($sformatf("v%0d_protocol", num), 64'(proto_err - pb), 64'd0);

        n      = log_q.size() - lb;
        nreads = 0;
        bad_rd = 0;
        k      = lb;
        while (k < log_q.size() && !log_q[k].wr) begin
            nreads++;
            if (log_q[k].addr != 8'h02) bad_rd++;
            k++;
        end
        chk($sformatf("v%0d_reads", num), 64'(nreads), 64'(v.exp_reads));
        chk($sformatf("v%0d_read_addr", num), 64'(bad_rd), 64'd0);

        if (v.exp_done) begin
            ew.push_back('{1'b1, 8'h10, v.exp_info});
            ew.push_back('{1'b1, 8'h11, v.exp_id1});
            ew.push_back('{1'b1, 8'h12, v.exp_id2});
            for (int i = 0; i < v.exp_nb; i++) begin
                ew.push_back('{1'b1, 8'(8'h13 + i), v.data[8*(7-i) +: 8]});
            end
            ew.push_back('{1'b1, 8'h01, 8'h01});
        end
        chk($sformatf("v%0d_write_count", num), 64'(n - nreads), 64'(ew.size()));
        for (int j = 0; j < ew.size() && (lb + nreads + j) < log_q.size(); j++) begin
            chk($sformatf("v%0d_wr%0d", num, j),
                64'({log_q[lb+nreads+j].wr, log_q[lb+nreads+j].addr, log_q[lb+nreads+j].data}),
                64'({ew[j].wr, ew[j].addr, ew[j].data}));
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   db, lb;
        bit   fin;

        //           id      rtr   dlc    data                     lock rd nb info   id1    id2    done
        vecs[0] = '{11'h123, 1'b0, 4'd2,  64'hAA55_0000_0000_0000, 0,   1, 2, 8'h02, 8'h24, 8'h60, 1'b1};
        vecs[1] = '{11'h7FF, 1'b0, 4'd8,  64'h0102_0304_0506_0708, 2,   3, 8, 8'h08, 8'hFF, 8'hE0, 1'b1};
        vecs[2] = '{11'h2AA, 1'b0, 4'd3,  64'hDEAD_BEEF_0000_0000, 255, 4, 0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{11'h123, 1'b1, 4'd5,  64'h1122_3344_5566_7788, 0,   1, 0, 8'h45, 8'h24, 8'h70, 1'b1};
        vecs[4] = '{11'h555, 1'b0, 4'd12, 64'hF0E1_D2C3_B4A5_9687, 0,   1, 8, 8'h0C, 8'hAA, 8'hA0, 1'b1};
        vecs[5] = '{11'h000, 1'b0, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 3,   4, 0, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{11'h400, 1'b0, 4'd1,  64'h5A00_0000_0000_0000, 1,   2, 1, 8'h01, 8'h80, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_wr_rd_en", 64'(bus_if.bus_wr_rd_en), 64'd0);
        chk("rst_addr",     64'(bus_if.bus_addr),     64'd0);
        chk("rst_wdata",    64'(bus_if.bus_wdata),    64'd0);
        chk("rst_busy",     64'(tx_busy),             64'd0);
        chk("rst_done",     64'(tx_done),             64'd0);
        chk("rst_timeout",  64'(tx_timeout),          64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // Extra start while busy, then reset during the third TX-buffer write.
        db           = done_cnt;
        lb           = log_q.size();
        locked_reads = 0;
        rd_base      = rd_total;
        @(negedge clk);
        tx_start = 1'b1;
        tx_id    = vecs[0].id;
        tx_rtr   = vecs[0].rtr;
        tx_dlc   = vecs[0].dlc;
        tx_data  = vecs[0].data;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (2) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 500 && !fin; c++) begin
            @(negedge clk);
            if (bus_if.bus_wr_rd_en == 2'b10 && bus_if.bus_addr == 8'h12) fin = 1'b1;
        end
        chk("rs_reached_load2", 64'(fin), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_wr_rd_en", 64'(bus_if.bus_wr_rd_en), 64'd0);
        chk("rs_addr",     64'(bus_if.bus_addr),     64'd0);
        chk("rs_wdata",    64'(bus_if.bus_wdata),    64'd0);
        chk("rs_busy",     64'(tx_busy),             64'd0);
        chk("rs_done",     64'(tx_done),             64'd0);
        chk("rs_timeout",  64'(tx_timeout),          64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rs_no_done",     64'(done_cnt - db),     64'd0);
        chk("rs_access_cnt",  64'(log_q.size() - lb), 64'd3);
        chk("rs_busy_after",  64'(tx_busy),           64'd0);

        run_frame(vecs[0], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
